// File: rtl/wb_pkg.sv
// Shared encodings for the write-back sequencer: MemToReg source selects and FSM states.
package wb_pkg;

  localparam logic [2:0] SRC_ALU     = 3'b000;
  localparam logic [2:0] SRC_LOAD    = 3'b001;
  localparam logic [2:0] SRC_HI      = 3'b010;
  localparam logic [2:0] SRC_LO      = 3'b011;
  localparam logic [2:0] SRC_SLT     = 3'b100;
  localparam logic [2:0] SRC_CONST   = 3'b101;
  localparam logic [2:0] SRC_LUI     = 3'b110;
  localparam logic [2:0] SRC_INVALID = 3'b111;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MEM,
    WAIT_MD,
    WRITE,
    ABORT
  } wb_state_t;

  function automatic logic src_is_valid(input logic [2:0] src);
    case (src)
      SRC_ALU, SRC_LOAD, SRC_HI, SRC_LO,
      SRC_SLT, SRC_CONST, SRC_LUI: return 1'b1;
      SRC_INVALID:                 return 1'b0;
      default:                     return 1'b0;
    endcase
  endfunction

  function automatic logic src_is_md(input logic [2:0] src);
    return (src == SRC_HI) || (src == SRC_LO);
  endfunction

endpackage

// File: rtl/wb_wait_timer.sv
// Wait-state counter: clear/enable, flags expiry when the count reaches TIMEOUT_CYCLES.
// Combinational expired output; no backpressure.
module wb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);
  // Expiry is flagged on the wait cycle whose increment would reach the limit.
  assign expired = en && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: one request at a time, write one cycle after the source is valid.
// Backpressure by holding wb_req until wb_ack; optional wait timeout under WB_TIMEOUT_EN.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wb_req,
  input  logic [2:0] wb_src,
  input  logic [4:0] wb_dst,
  input  logic       mem_ready,
  input  logic       md_busy,
  output logic [2:0] mem_to_reg,
  output logic       reg_write,
  output logic [4:0] reg_dst_addr,
  output logic       wb_ack,
  output logic       wb_err,
  output logic       wb_busy
);

  wb_state_t  state;
  wb_state_t  state_nxt;
  logic [2:0] src_q;
  logic [4:0] dst_q;
  logic       wait_expired;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      src_q <= SRC_ALU;
      dst_q <= REG_ZERO;
    end else begin
      state <= state_nxt;
      if (state == IDLE && wb_req) begin
        src_q <= wb_src;
        dst_q <= wb_dst;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_to_reg   = SRC_ALU;
    reg_write    = 1'b0;
    reg_dst_addr = REG_ZERO;
    wb_ack       = 1'b0;
    wb_err       = 1'b0;
    wb_busy      = 1'b1;

    case (state)
      IDLE: begin
        wb_busy = 1'b0;
        if (wb_req) begin
          if (!src_is_valid(wb_src)) begin
            state_nxt = ABORT;
          end else if (wb_src == SRC_LOAD && !mem_ready) begin
            state_nxt = WAIT_MEM;
          end else if (src_is_md(wb_src) && md_busy) begin
            state_nxt = WAIT_MD;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      // A source turning valid on the expiry cycle still gets its write.
      WAIT_MEM: begin
        if (mem_ready) begin
          state_nxt = WRITE;
        end else if (wait_expired) begin
          state_nxt = ABORT;
        end
      end
      WAIT_MD: begin
        if (!md_busy) begin
          state_nxt = WRITE;
        end else if (wait_expired) begin
          state_nxt = ABORT;
        end
      end
      WRITE: begin
        reg_write = (dst_q != REG_ZERO);
        wb_ack    = 1'b1;
        state_nxt = IDLE;
      end
      ABORT: begin
        wb_ack    = 1'b1;
        wb_err    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state != IDLE) begin
      mem_to_reg   = src_q;
      reg_dst_addr = dst_q;
    end
  end

`ifdef WB_TIMEOUT_EN
  logic in_wait;

  assign in_wait = (state == WAIT_MEM) || (state == WAIT_MD);

  wb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (wait_expired)
  );
`else
  logic unused_timeout_cfg;

  assign wait_expired       = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: table vectors, hand sequences and randomized requests
// checked cycle-by-cycle against a timeline model of request latency.
module tb_wb_sequencer;

  localparam int TO_T = 4;

  logic       clk;
  logic       reset_n;
  logic       wb_req;
  logic [2:0] wb_src;
  logic [4:0] wb_dst;
  logic       mem_ready;
  logic       md_busy;
  logic [2:0] mem_to_reg;
  logic       reg_write;
  logic [4:0] reg_dst_addr;
  logic       wb_ack;
  logic       wb_err;
  logic       wb_busy;
  logic [11:0] outs;

  int checks   = 0;
  int failures = 0;

  wb_sequencer #(
    .TIMEOUT_CYCLES(TO_T)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wb_req       (wb_req),
    .wb_src       (wb_src),
    .wb_dst       (wb_dst),
    .mem_ready    (mem_ready),
    .md_busy      (md_busy),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .reg_dst_addr (reg_dst_addr),
    .wb_ack       (wb_ack),
    .wb_err       (wb_err),
    .wb_busy      (wb_busy)
  );

  assign outs = {mem_to_reg, reg_write, reg_dst_addr, wb_ack, wb_err, wb_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0] src;
    logic [4:0] dst;
    int         d;      // cycles until the waited-on source turns valid
    int         ack_t;  // expected cycle (after request edge) carrying wb_ack
    bit         we;
    bit         err;
  } vec_t;

  function automatic logic [11:0] mk(input logic [2:0] m2r, input logic we,
                                     input logic [4:0] dst, input logic ack,
                                     input logic err, input logic busy);
    return {m2r, we, dst, ack, err, busy};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: outputs {m2r,we,dst,ack,err,busy} got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ready(input logic [2:0] s, input int t, input int d);
    mem_ready = (s == 3'b001) ? (t >= d) : 1'($urandom);
    md_busy   = (s == 3'b010 || s == 3'b011) ? (t < d) : 1'($urandom);
  endtask

  // Reference model: a request sampled at edge 0 retires in cycle ack_t.
  task automatic predict(input logic [2:0] s, input logic [4:0] r, input int d,
                         output int ack_t, output bit we, output bit err);
    bit waits;
    waits = (s == 3'b001 || s == 3'b010 || s == 3'b011);
    err   = 1'b0;
    ack_t = 1;
    if (s == 3'b111) begin
      err = 1'b1;
    end else if (waits && d > 0) begin
      ack_t = d + 1;
`ifdef WB_TIMEOUT_EN
      if (d > TO_T) begin
        ack_t = TO_T + 1;
        err   = 1'b1;
      end
`endif
    end
    we = !err && (r != 5'd0);
  endtask

  // Entered in an IDLE cycle; leaves the DUT in IDLE with wb_req low.
  task automatic do_txn(input string name, input logic [2:0] s, input logic [4:0] r,
                        input int d, input int ack_t, input bit we, input bit err);
    wb_req = 1'b1;
    wb_src = s;
    wb_dst = r;
    drive_ready(s, 0, d);
    for (int t = 0; t < ack_t; t++) begin
      step();
      if (t + 1 == ack_t)
        chk({name, "_ack"}, outs, mk(s, we, r, 1'b1, err, 1'b1));
      else
        chk({name, "_wait"}, outs, mk(s, 1'b0, r, 1'b0, 1'b0, 1'b1));
      wb_src = 3'($urandom);
      wb_dst = 5'($urandom);
      drive_ready(s, t + 1, d);
    end
    wb_req = 1'($urandom);
    step();
    chk({name, "_idle"}, outs, 12'h000);
    wb_req = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    int   ack_t;
    bit   we;
    bit   err;
    logic [2:0] s;
    logic [4:0] r;
    int   d;

    vecs.push_back('{3'b000, 5'd8,  0, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b001, 5'd9,  3, 4, 1'b1, 1'b0});
`ifdef WB_TIMEOUT_EN
    vecs.push_back('{3'b010, 5'd10, 34, TO_T + 1, 1'b0, 1'b1});
    vecs.push_back('{3'b001, 5'd9,  100, TO_T + 1, 1'b0, 1'b1});
    vecs.push_back('{3'b001, 5'd9,  TO_T, TO_T + 1, 1'b1, 1'b0});
    vecs.push_back('{3'b011, 5'd14, TO_T + 1, TO_T + 1, 1'b0, 1'b1});
`else
    vecs.push_back('{3'b010, 5'd10, 34, 35, 1'b1, 1'b0});
`endif
    vecs.push_back('{3'b011, 5'd31, 0, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b100, 5'd0,  0, 1, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 5'd12, 0, 1, 1'b0, 1'b1});
    vecs.push_back('{3'b101, 5'd1,  3, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b110, 5'd30, 2, 1, 1'b1, 1'b0});
    vecs.push_back('{3'b001, 5'd0,  2, 3, 1'b0, 1'b0});
    vecs.push_back('{3'b011, 5'd7,  1, 2, 1'b1, 1'b0});

    reset_n   = 1'b0;
    wb_req    = 1'b0;
    wb_src    = 3'b000;
    wb_dst    = 5'd0;
    mem_ready = 1'b0;
    md_busy   = 1'b0;
    step();
    // Request held during reset must not be taken.
    wb_req = 1'b1;
    wb_src = 3'b101;
    wb_dst = 5'd3;
    step();
    chk("reset_state", outs, 12'h000);
    wb_req  = 1'b0;
    reset_n = 1'b1;
    step();
    chk("post_reset_idle", outs, 12'h000);

    foreach (vecs[i])
      do_txn($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].d,
             vecs[i].ack_t, vecs[i].we, vecs[i].err);

    // Reset during WAIT_MD: outputs clear and the pending write is dropped.
    wb_req  = 1'b1;
    wb_src  = 3'b010;
    wb_dst  = 5'd20;
    md_busy = 1'b1;
    step();
    chk("rst_wait_busy", outs, mk(3'b010, 1'b0, 5'd20, 1'b0, 1'b0, 1'b1));
    wb_req = 1'b0;
    step();
    chk("rst_wait_busy2", outs, mk(3'b010, 1'b0, 5'd20, 1'b0, 1'b0, 1'b1));
    reset_n = 1'b0;
    step();
    chk("rst_mid_wait", outs, 12'h000);
    reset_n = 1'b1;
    md_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_no_write", outs, 12'h000);
    end

    // Back-to-back requests with random sources, delays and idle gaps.
    for (int n = 0; n < 300; n++) begin
      int gap;
      s = 3'($urandom);
      r = 5'($urandom);
      d = $urandom_range(0, 6);
      predict(s, r, d, ack_t, we, err);
      do_txn($sformatf("rand%0d", n), s, r, d, ack_t, we, err);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        wb_src = 3'($urandom);
        wb_dst = 5'($urandom);
        step();
        chk("rand_gap_idle", outs, 12'h000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back sequencer for the multicycle MIPS datapath. It accepts one register-file write request at a time from the main control FSM and drives the MemToReg mux select, RegWrite and the destination address. Before committing the write, it waits for the selected source to become valid: load data from memory, or HI/LO from the mult/div unit. It sits between the control unit and the Mux_MemToReg / register-bank pair.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum wait-state cycles before a request is aborted (used only with WB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- wb_req  in  1  write-back request. Held high, with wb_src and wb_dst stable, until wb_ack.
- wb_src  in  3  source select, in MemToReg encoding:
  - 000 ALUOut
  - 001 load result
  - 010 HI
  - 011 LO
  - 100 SLT
  - 101 constant 227
  - 110 LUI shift
  - 111 invalid
- wb_dst  in  5  destination register number.
- mem_ready  in  1  load-size result valid this cycle.
- md_busy  in  1  mult/div in progress; HI/LO not yet valid.
- mem_to_reg  out  3  select to Mux_MemToReg.
- reg_write  out  1  register-bank write enable.
- reg_dst_addr  out  5  register-bank write address.
- wb_ack  out  1  one-cycle pulse: request retired.
- wb_err  out  1  one-cycle pulse, coincident with wb_ack: request retired without a write.
- wb_busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT_MEM, WAIT_MD, WRITE, ABORT.
- IDLE, with wb_req=1: latch wb_src and wb_dst, then select the next state.
  - wb_src=111 → ABORT.
  - wb_src=001 and mem_ready=0 → WAIT_MEM.
  - wb_src∈{010,011} and md_busy=1 → WAIT_MD.
  - Otherwise → WRITE.
- WAIT_MEM → WRITE on the first cycle with mem_ready=1.
- WAIT_MD → WRITE on the first cycle with md_busy=0.
- WRITE (one cycle): assert reg_write and wb_ack, then return to IDLE.
  - If the latched dst is 0, reg_write is forced to 0; wb_ack still pulses and wb_err stays 0.
- ABORT (one cycle): assert wb_ack and wb_err with reg_write=0, then return to IDLE.
- mem_to_reg and reg_dst_addr hold the latched values in every non-IDLE state. They are 000 and 0 in IDLE.
- wb_src and wb_dst changes while busy are ignored; the latched copies are used.
- If wb_req is still high in the cycle after wb_ack, it is a new request, evaluated in IDLE.
- mem_ready and md_busy are ignored for sources that do not use them.

## Timing
- Reset: state=IDLE, and mem_to_reg=000, reg_write=0, reg_dst_addr=0, wb_ack=0, wb_err=0, wb_busy=0. Wait counter = 0. Reset takes priority over all transitions, including mid-WAIT or WRITE (no write occurs).
- Latency for a ready source: request sampled at edge N; reg_write and wb_ack are high during cycle N+1.
- Latency for a wait source: WRITE occupies the cycle after the edge where mem_ready=1 or md_busy=0 is sampled.
- Minimum spacing between consecutive writes: 2 cycles (IDLE, WRITE).
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- WB_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT_MEM/WAIT_MD and increments each wait cycle.
  - When the counter reaches TIMEOUT_CYCLES, the next state is ABORT.
  - If the source becomes ready on that same cycle, ready wins → WRITE.
- WB_TIMEOUT_EN undefined:
  - No counter is instantiated.
  - WAIT states hold indefinitely.
  - ABORT is reached only via wb_src=111.

## Structure
- Package wb_pkg holds:
  - localparams for the seven source encodings and SRC_INVALID=3'b111.
  - the state enum: IDLE, WAIT_MEM, WAIT_MD, WRITE, ABORT.
  - REG_ZERO=5'd0.
- One sub-module, wb_wait_timer: clear/enable/expired counter of width $clog2(TIMEOUT_CYCLES+1). Instantiated only under WB_TIMEOUT_EN.

## Test plan
- Ready ALU source: req src=000 dst=8 at edge 1 → in cycle 2, reg_write=1, reg_dst_addr=8, mem_to_reg=000, wb_ack=1; IDLE in cycle 3.
- Load source: req src=001 dst=9, mem_ready low for 3 cycles → wb_busy=1, mem_to_reg=001 and reg_write=0 for 3 cycles; WRITE in the cycle after mem_ready rises.
- HI source: req src=010 dst=10 with md_busy=1 for 34 cycles → write one cycle after md_busy falls; changing wb_dst to 11 mid-wait still writes register 10.
- Register 0 and invalid source:
  - req src=100 dst=0 → wb_ack=1, reg_write=0, wb_err=0.
  - req src=111 → wb_ack=1, wb_err=1, reg_write=0.
- Timeout (WB_TIMEOUT_EN, TIMEOUT_CYCLES=4): load with mem_ready held low → ABORT after 4 wait cycles, wb_err=1. Second run with mem_ready rising on the 4th wait cycle → WRITE, wb_err=0.
- Reset mid-wait: reset_n low during WAIT_MD → next cycle all outputs zero and state IDLE; no reg_write pulse after md_busy falls.
